// File: rtl/gpr_pkg.sv
// Shared size encodings and lane helpers for the multi-port GPR file.
package gpr_pkg;

  // Access size encoding, shared by read and write ports.
  localparam logic [1:0] SZ_8LO = 2'b00;
  localparam logic [1:0] SZ_8HI = 2'b01;
  localparam logic [1:0] SZ_16  = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  // Which parts of a register a write touches: byte 0, byte 1, bits above 15.
  typedef struct packed {
    logic upper;
    logic hi;
    logic lo;
  } lane_mask_t;

  // Lane enable mask for a given write size.
  function automatic lane_mask_t lane_mask(input logic [1:0] sz);
    lane_mask_t m;
    m = '0;
    case (sz)
      SZ_8LO: m.lo = 1'b1;
      SZ_8HI: m.hi = 1'b1;
      SZ_16: begin
        m.lo = 1'b1;
        m.hi = 1'b1;
      end
      default: begin
        m.lo = 1'b1;
        m.hi = 1'b1;
        m.upper = 1'b1;
      end
    endcase
    return m;
  endfunction

  // Zero-extended formatting of the low 16 bits for sub-register reads.
  // Full-width reads bypass this and take the whole register.
  function automatic logic [15:0] fmt_low16(input logic [1:0] sz, input logic [15:0] low);
    logic [15:0] r;
    case (sz)
      SZ_8LO: r = {8'h00, low[7:0]};
      SZ_8HI: r = {8'h00, low[15:8]};
      default: r = low;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpr_lane_merge.sv
// Next-value computation for one register: merges every write port that
// targets REG_ID, byte-lane by byte-lane, with higher-numbered ports winning.
module gpr_lane_merge
  import gpr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NWR = 3,
  parameter int IDW = 3,
  parameter int REG_ID = 0
) (
  input  logic [WIDTH-1:0]     cur,
  input  logic [NWR-1:0]       wv,
  input  logic [NWR*IDW-1:0]   wid,
  input  logic [NWR*2-1:0]     wsz,
  input  logic [NWR*WIDTH-1:0] wdin,
  output logic [WIDTH-1:0]     merged,
  output logic                 hit
);

  localparam logic [IDW-1:0] MY_ID = IDW'(REG_ID);

  lane_mask_t       lm;
  logic [1:0]       sz;
  logic [WIDTH-1:0] aligned;

  // Apply ports in ascending order so the highest-numbered port overrides.
  always_comb begin
    merged = cur;
    hit = 1'b0;
    lm = '0;
    sz = SZ_8LO;
    aligned = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wv[p] && (wid[p*IDW +: IDW] == MY_ID)) begin
        hit = 1'b1;
        sz = wsz[p*2 +: 2];
        lm = lane_mask(sz);
        aligned = wdin[p*WIDTH +: WIDTH];
        // High-byte writes take their data from the low byte of WDIN.
        if (sz == SZ_8HI) aligned[15:8] = aligned[7:0];
        for (int b = 0; b < WIDTH; b++) begin
          if ((b < 8 && lm.lo) || (b >= 8 && b < 16 && lm.hi) || (b >= 16 && lm.upper))
            merged[b] = aligned[b];
        end
      end
    end
  end

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with x86 sub-register sizing, lane-merged write
// conflicts, optional write-to-read bypass and a per-register pending vector.
// Interface note: there is no valid/ready handshake; WV and ISV are
// single-cycle qualifiers sampled at every rising edge and never back-pressured.
module gpr_file_mp
  import gpr_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 32,
  parameter int NRD = 4,
  parameter int NWR = 3,
  parameter int BYPASS = 1,
  localparam int IDW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [NRD*IDW-1:0]   RID,
  input  logic [NRD*2-1:0]     RSZ,
  output logic [NRD*WIDTH-1:0] DOUT,
  output logic [NRD-1:0]       RBUSY,
  input  logic [NWR-1:0]       WV,
  input  logic [NWR*IDW-1:0]   WID,
  input  logic [NWR*2-1:0]     WSZ,
  input  logic [NWR*WIDTH-1:0] WDIN,
  input  logic [NWR-1:0]       WREL,
  input  logic                 ISV,
  input  logic [IDW-1:0]       ISID,
  output logic [NREGS-1:0]     PEND
);

  logic [WIDTH-1:0] regs   [NREGS];
  logic [WIDTH-1:0] merged [NREGS];
  logic [NREGS-1:0] hit;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] rel_hit;
  logic [NREGS-1:0] set_hit;

  // One merge unit per register; its result feeds storage and the bypass mux.
  for (genvar r = 0; r < NREGS; r++) begin : g_merge
    gpr_lane_merge #(
      .WIDTH (WIDTH),
      .NWR   (NWR),
      .IDW   (IDW),
      .REG_ID(r)
    ) u_merge (
      .cur   (regs[r]),
      .wv    (WV),
      .wid   (WID),
      .wsz   (WSZ),
      .wdin  (WDIN),
      .merged(merged[r]),
      .hit   (hit[r])
    );
  end

  // Register storage: reset clears everything, otherwise take merged value.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!CLR) regs[r] <= '0;
      else if (hit[r]) regs[r] <= merged[r];
    end
  end

  // Decode releases (valid write with WREL) and the single issue claim.
  always_comb begin
    rel_hit = '0;
    set_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (WV[p] && WREL[p] && (WID[p*IDW +: IDW] == IDW'(r))) rel_hit[r] = 1'b1;
      end
      if (ISV && (ISID == IDW'(r))) set_hit[r] = 1'b1;
    end
  end

  // Pending scoreboard: a new claim outranks a same-cycle release.
  always_ff @(posedge CLK) begin
    if (!CLR) pend <= '0;
    else pend <= set_hit | (pend & ~rel_hit);
  end

  assign PEND = pend;

  logic [IDW-1:0]   rd_id;
  logic [1:0]       rd_sz;
  logic [WIDTH-1:0] rd_src;
  logic             rd_busy;

  // Read muxes: out-of-range IDs match no register and read as zero / not busy.
  // RBUSY always comes from registered pend, never from same-cycle updates.
  always_comb begin
    DOUT = '0;
    RBUSY = '0;
    rd_id = '0;
    rd_sz = SZ_8LO;
    rd_src = '0;
    rd_busy = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rd_id = RID[p*IDW +: IDW];
      rd_sz = RSZ[p*2 +: 2];
      rd_src = '0;
      rd_busy = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (rd_id == IDW'(r)) begin
          rd_src = (BYPASS != 0) ? merged[r] : regs[r];
          rd_busy = pend[r];
        end
      end
      DOUT[p*WIDTH +: WIDTH] = (rd_sz == SZ_FULL) ? rd_src : WIDTH'(fmt_low16(rd_sz, rd_src[15:0]));
      RBUSY[p] = rd_busy;
    end
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: one bypassing and one non-bypassing
// instance share stimulus and are compared against a byte-level reference model.
module tb_gpr_file_mp;

  logic         clk;
  logic         clr;
  logic [11:0]  rid;
  logic [7:0]   rsz;
  logic [127:0] dout_b;
  logic [127:0] dout_n;
  logic [3:0]   rbusy_b;
  logic [3:0]   rbusy_n;
  logic [2:0]   wv;
  logic [8:0]   wid;
  logic [5:0]   wsz;
  logic [95:0]  wdin;
  logic [2:0]   wrel;
  logic         isv;
  logic [2:0]   isid;
  logic [7:0]   pend_b;
  logic [7:0]   pend_n;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state.
  logic [31:0] m_regs [8];
  logic [7:0]  m_pend;

  gpr_file_mp #(.BYPASS(1)) dut (
    .CLK(clk), .CLR(clr), .RID(rid), .RSZ(rsz), .DOUT(dout_b), .RBUSY(rbusy_b),
    .WV(wv), .WID(wid), .WSZ(wsz), .WDIN(wdin), .WREL(wrel), .ISV(isv), .ISID(isid),
    .PEND(pend_b)
  );

  gpr_file_mp #(.BYPASS(0)) dut_nb (
    .CLK(clk), .CLR(clr), .RID(rid), .RSZ(rsz), .DOUT(dout_n), .RBUSY(rbusy_n),
    .WV(wv), .WID(wid), .WSZ(wsz), .WDIN(wdin), .WREL(wrel), .ISV(isv), .ISID(isid),
    .PEND(pend_n)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] fmt(input logic [31:0] r, input logic [1:0] sz);
    case (sz)
      2'd0: return r & 32'hff;
      2'd1: return (r >> 8) & 32'hff;
      2'd2: return r & 32'hffff;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] apply_wr(input logic [31:0] r, input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0: return (r & ~32'hff) | (d & 32'hff);
      2'd1: return (r & ~32'hff00) | ((d & 32'hff) << 8);
      2'd2: return (r & ~32'hffff) | (d & 32'hffff);
      default: return d;
    endcase
  endfunction

  // Value register i takes after this cycle's writes (later ports win).
  function automatic logic [31:0] m_next(input int i);
    logic [31:0] v;
    v = m_regs[i];
    for (int p = 0; p < 3; p++)
      if (wv[p] && int'(wid[p*3 +: 3]) == i) v = apply_wr(v, wsz[p*2 +: 2], wdin[p*32 +: 32]);
    return v;
  endfunction

  task automatic model_step();
    logic [31:0] nxt [8];
    logic rel;
    if (!clr) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pend = '0;
    end else begin
      for (int i = 0; i < 8; i++) nxt[i] = m_next(i);
      for (int i = 0; i < 8; i++) begin
        rel = 1'b0;
        for (int p = 0; p < 3; p++)
          if (wv[p] && wrel[p] && int'(wid[p*3 +: 3]) == i) rel = 1'b1;
        if (isv && int'(isid) == i) m_pend[i] = 1'b1;
        else if (rel) m_pend[i] = 1'b0;
        m_regs[i] = nxt[i];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    wv = '0;
    wrel = '0;
    isv = 1'b0;
    clr = 1'b1;
    #1;
  endtask

  task automatic drv_wr(input int p, input int id, input logic [1:0] sz, input logic [31:0] d, input logic rel);
    wv[p] = 1'b1;
    wid[p*3 +: 3] = 3'(id);
    wsz[p*2 +: 2] = sz;
    wdin[p*32 +: 32] = d;
    wrel[p] = rel;
  endtask

  task automatic drv_rd(input int p, input int id, input logic [1:0] sz);
    rid[p*3 +: 3] = 3'(id);
    rsz[p*2 +: 2] = sz;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b0;
    tick();
    for (int id = 0; id < 8; id++) begin
      for (int sz = 0; sz < 4; sz++) begin
        for (int p = 0; p < 4; p++) drv_rd(p, id, 2'(sz));
        #1;
        n_tests++;
        if (dout_b !== 128'd0 || dout_n !== 128'd0) begin
          n_fail++;
          $display("FAIL reset_dout id=%0d sz=%0d got b=%h n=%h want 0", id, sz, dout_b, dout_n);
        end
        n_tests++;
        if (rbusy_b !== 4'd0 || rbusy_n !== 4'd0) begin
          n_fail++;
          $display("FAIL reset_rbusy id=%0d got b=%h n=%h want 0", id, rbusy_b, rbusy_n);
        end
      end
    end
    n_tests++;
    if (pend_b !== 8'd0 || pend_n !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_pend got b=%h n=%h want 00", pend_b, pend_n);
    end
  endtask

  task automatic test_subreg();
    logic [31:0] want [4];
    drv_wr(0, 0, 2'd3, 32'h12345678, 1'b0);
    tick();
    drv_wr(1, 0, 2'd1, 32'h000000AB, 1'b0);
    tick();
    drv_rd(0, 0, 2'd3);
    drv_rd(1, 0, 2'd1);
    drv_rd(2, 0, 2'd2);
    drv_rd(3, 0, 2'd0);
    #1;
    want[0] = 32'h1234AB78;
    want[1] = 32'h000000AB;
    want[2] = 32'h0000AB78;
    want[3] = 32'h00000078;
    for (int p = 0; p < 4; p++) begin
      n_tests++;
      if (dout_b[p*32 +: 32] !== want[p] || dout_n[p*32 +: 32] !== want[p]) begin
        n_fail++;
        $display("FAIL subreg port=%0d got b=%h n=%h want %h", p, dout_b[p*32 +: 32], dout_n[p*32 +: 32], want[p]);
      end
    end
  endtask

  task automatic test_conflict();
    drv_wr(0, 3, 2'd3, 32'hFFFFFFFF, 1'b0);
    drv_wr(2, 3, 2'd2, 32'h00000000, 1'b0);
    tick();
    drv_rd(0, 3, 2'd3);
    #1;
    n_tests++;
    if (dout_n[31:0] !== 32'hFFFF0000) begin
      n_fail++;
      $display("FAIL conflict_hi_wins got %h want FFFF0000", dout_n[31:0]);
    end
    drv_wr(0, 3, 2'd2, 32'h00000000, 1'b0);
    drv_wr(2, 3, 2'd3, 32'hFFFFFFFF, 1'b0);
    tick();
    n_tests++;
    if (dout_n[31:0] !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL conflict_swapped got %h want FFFFFFFF", dout_n[31:0]);
    end
  endtask

  task automatic test_bypass();
    drv_wr(0, 1, 2'd3, 32'h11223344, 1'b0);
    tick();
    drv_wr(0, 1, 2'd0, 32'h0000005A, 1'b0);
    drv_rd(0, 1, 2'd3);
    #1;
    n_tests++;
    if (dout_b[31:0] !== 32'h1122335A) begin
      n_fail++;
      $display("FAIL bypass_same_cycle got %h want 1122335A", dout_b[31:0]);
    end
    n_tests++;
    if (dout_n[31:0] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle got %h want 11223344", dout_n[31:0]);
    end
    tick();
    n_tests++;
    if (dout_b[31:0] !== 32'h1122335A || dout_n[31:0] !== 32'h1122335A) begin
      n_fail++;
      $display("FAIL bypass_after got b=%h n=%h want 1122335A", dout_b[31:0], dout_n[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    for (int p = 0; p < 4; p++) drv_rd(p, 2, 2'd3);
    isv = 1'b1;
    isid = 3'd2;
    #1;
    n_tests++;
    if (rbusy_b !== 4'h0) begin
      n_fail++;
      $display("FAIL rbusy_no_bypass got %h want 0", rbusy_b);
    end
    tick();
    n_tests++;
    if (pend_b !== 8'h04 || rbusy_b !== 4'hF || rbusy_n !== 4'hF) begin
      n_fail++;
      $display("FAIL issue_set pend=%h rbusy=%h want pend 04 rbusy F", pend_b, rbusy_b);
    end
    isv = 1'b1;
    isid = 3'd2;
    drv_wr(1, 2, 2'd3, 32'hA5A5A5A5, 1'b1);
    tick();
    n_tests++;
    if (pend_b !== 8'h04 || dout_n[31:0] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL set_beats_clear pend=%h data=%h want 04 A5A5A5A5", pend_b, dout_n[31:0]);
    end
    drv_wr(2, 2, 2'd0, 32'h00000001, 1'b1);
    tick();
    n_tests++;
    if (pend_b !== 8'h00 || rbusy_b !== 4'h0) begin
      n_fail++;
      $display("FAIL release pend=%h rbusy=%h want 00 0", pend_b, rbusy_b);
    end
  endtask

  task automatic test_reset_mid();
    drv_wr(0, 5, 2'd3, 32'h0BADF00D, 1'b0);
    isv = 1'b1;
    isid = 3'd6;
    tick();
    drv_wr(1, 5, 2'd3, 32'hDEADBEEF, 1'b0);
    isv = 1'b1;
    isid = 3'd6;
    clr = 1'b0;
    drv_rd(0, 5, 2'd3);
    tick();
    n_tests++;
    if (dout_n[31:0] !== 32'h0 || pend_b !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid data=%h pend=%h want 0 00", dout_n[31:0], pend_b);
    end
    drv_wr(2, 5, 2'd3, 32'hCAFEF00D, 1'b0);
    tick();
    n_tests++;
    if (dout_n[31:0] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL write_after_reset got %h want CAFEF00D", dout_n[31:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] eb;
    logic [31:0] en;
    int id;
    logic [1:0] sz;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 1) == 1)
          drv_wr(p, $urandom_range(0, 7), 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      end
      isv = 1'($urandom_range(0, 2) == 0);
      isid = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
      for (int p = 0; p < 4; p++) drv_rd(p, $urandom_range(0, 7), 2'($urandom_range(0, 3)));
      #1;
      for (int p = 0; p < 4; p++) begin
        id = int'(rid[p*3 +: 3]);
        sz = rsz[p*2 +: 2];
        en = fmt(m_regs[id], sz);
        eb = fmt(m_next(id), sz);
        n_tests++;
        if (dout_n[p*32 +: 32] !== en || (clr && dout_b[p*32 +: 32] !== eb)) begin
          n_fail++;
          $display("FAIL rand_read c=%0d port=%0d got b=%h n=%h want b=%h n=%h",
                   c, p, dout_b[p*32 +: 32], dout_n[p*32 +: 32], eb, en);
        end
        n_tests++;
        if (rbusy_b[p] !== m_pend[id] || rbusy_n[p] !== m_pend[id]) begin
          n_fail++;
          $display("FAIL rand_rbusy c=%0d port=%0d got %b want %b", c, p, rbusy_b[p], m_pend[id]);
        end
      end
      tick();
      n_tests++;
      if (pend_b !== m_pend || pend_n !== m_pend) begin
        n_fail++;
        $display("FAIL rand_pend c=%0d got b=%h n=%h want %h", c, pend_b, pend_n, m_pend);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    clr = 1'b0;
    rid = '0;
    rsz = '0;
    wv = '0;
    wid = '0;
    wsz = '0;
    wdin = '0;
    wrel = '0;
    isv = 1'b0;
    isid = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_pend = '0;
    @(negedge clk);
    test_reset();
    test_subreg();
    test_conflict();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
